// File: rtl/wb_counter_pkg.sv
// Shared types and constants for the Wishbone-to-counter bridge.
//   state_t       : bridge FSM states (IDLE, REQ, RESP)
//   DEF_*         : default address map and error data
//   FLAG_BIT,
//   ERRCNT_LSB    : field positions inside the status word
//   status_word() : assembles the status word from the flag and error count
//   sat_inc8()    : 8-bit saturating increment for the error counter
package wb_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR     = 32'h3000_0000;
  localparam logic [31:0] DEF_STATUS_OFFSET = 32'h0000_0004;
  localparam logic [31:0] DEF_ERR_DATA      = 32'hDEAD_BEEF;

  localparam int FLAG_BIT   = 0;
  localparam int ERRCNT_LSB = 8;
  localparam int ERRCNT_W   = 8;

  // Status word: error count in [15:8], sticky timeout flag in [0], rest zero.
  function automatic logic [31:0] status_word(input logic flag, input logic [7:0] err);
    logic [31:0] w;
    w                         = 32'h0000_0000;
    w[FLAG_BIT]               = flag;
    w[ERRCNT_LSB +: ERRCNT_W] = err;
    return w;
  endfunction

  // Counter sticks at 255 rather than wrapping back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decode for the bridge.
//   adr      in  32  Wishbone byte address
//   hit_data out 1   address selects the counter data word
//   hit_stat out 1   address selects the status word
module wb_addr_decode
  import wb_counter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
  parameter logic [31:0] STATUS_OFFSET = DEF_STATUS_OFFSET
) (
  input  logic [31:0] adr,
  output logic        hit_data,
  output logic        hit_stat
);

  localparam logic [31:0] STAT_ADDR = BASE_ADDR + STATUS_OFFSET;

  assign hit_data = (adr == BASE_ADDR);
  assign hit_stat = (adr == STAT_ADDR);

endmodule

// File: rtl/wb_counter_bridge.sv
// Wishbone classic slave in front of the user-area counter.
// Turns bus cycles at BASE_ADDR into a valid/wstrb/wdata request and waits
// for the counter's ready/rdata pulse; a status word at BASE_ADDR+STATUS_OFFSET
// exposes a sticky timeout flag (write 1 to bit 0 to clear) and a saturating
// timeout error count.
//   wb_clk_i, wb_rst_i          clock, async active-high reset
//   wbs_cyc_i/stb_i/we_i/sel_i  Wishbone request qualifiers
//   wbs_adr_i, wbs_dat_i        byte address, write data
//   wbs_ack_o, wbs_dat_o        one-cycle ack, read data (held between acks)
//   valid, wstrb, wdata         request to the counter (wstrb==0 is a read)
//   ready, rdata                counter response pulse and read data
//   timeout_flag                sticky timeout indicator (IRQ capable)
module wb_counter_bridge
  import wb_counter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
  parameter logic [31:0] STATUS_OFFSET = DEF_STATUS_OFFSET,
  parameter int          BITS          = 30,
  parameter int          TIMEOUT       = 16,
  parameter logic [31:0] ERR_DATA      = DEF_ERR_DATA
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  output logic            valid,
  output logic [3:0]      wstrb,
  output logic [BITS-1:0] wdata,
  input  logic            ready,
  input  logic [BITS-1:0] rdata,
  output logic            timeout_flag
);

  localparam int TMO_W = $clog2(TIMEOUT);

  state_t            state, state_n;
  logic              hit_data, hit_stat, req;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_n;
  logic [7:0]        err_count, err_count_n;
  logic              valid_n, ack_n, flag_n;
  logic [3:0]        wstrb_n;
  logic [BITS-1:0]   wdata_n;
  logic [31:0]       dat_n;

  wb_addr_decode #(
    .BASE_ADDR    (BASE_ADDR),
    .STATUS_OFFSET(STATUS_OFFSET)
  ) u_decode (
    .adr     (wbs_adr_i),
    .hit_data(hit_data),
    .hit_stat(hit_stat)
  );

  assign req = wbs_cyc_i & wbs_stb_i;

  // Write-data bits above the counter width never reach the counter.
  if (BITS < 32) begin : g_unused_dat
    logic unused_dat_hi;
    assign unused_dat_hi = ^wbs_dat_i[31:BITS];
  end

  // Next-state and next-register values; every output is registered.
  always_comb begin
    state_n     = state;
    valid_n     = valid;
    wstrb_n     = wstrb;
    wdata_n     = wdata;
    dat_n       = wbs_dat_o;
    ack_n       = 1'b0;
    flag_n      = timeout_flag;
    tmo_cnt_n   = tmo_cnt;
    err_count_n = err_count;
    case (state)
      IDLE: begin
        if (req && hit_data) begin
          state_n   = REQ;
          valid_n   = 1'b1;
          wstrb_n   = wbs_we_i ? wbs_sel_i : 4'b0000;
          wdata_n   = wbs_dat_i[BITS-1:0];
          tmo_cnt_n = '0;
        end else if (req && hit_stat) begin
          // Read value shows the flag as it was before any W1C clear.
          state_n = RESP;
          ack_n   = 1'b1;
          dat_n   = status_word(timeout_flag, err_count);
          if (wbs_we_i && wbs_sel_i[0] && wbs_dat_i[FLAG_BIT]) begin
            flag_n = 1'b0;
          end else begin
            flag_n = timeout_flag;
          end
        end else begin
          state_n = IDLE;
        end
      end
      REQ: begin
        // ready is checked first so a response on the timeout cycle still wins.
        if (ready) begin
          valid_n = 1'b0;
          dat_n   = 32'(rdata);
          ack_n   = 1'b1;
          state_n = RESP;
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          valid_n     = 1'b0;
          dat_n       = ERR_DATA;
          ack_n       = 1'b1;
          flag_n      = 1'b1;
          err_count_n = sat_inc8(err_count);
          state_n     = RESP;
        end else if (!wbs_cyc_i) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end else begin
          tmo_cnt_n = tmo_cnt + TMO_W'(1);
        end
      end
      RESP: begin
        // One-cycle ack; stb is not resampled here.
        ack_n   = 1'b0;
        state_n = IDLE;
      end
      default: begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      valid        <= 1'b0;
      wstrb        <= 4'b0000;
      wdata        <= '0;
      wbs_dat_o    <= 32'h0000_0000;
      wbs_ack_o    <= 1'b0;
      timeout_flag <= 1'b0;
      tmo_cnt      <= '0;
      err_count    <= 8'd0;
    end else begin
      state        <= state_n;
      valid        <= valid_n;
      wstrb        <= wstrb_n;
      wdata        <= wdata_n;
      wbs_dat_o    <= dat_n;
      wbs_ack_o    <= ack_n;
      timeout_flag <= flag_n;
      tmo_cnt      <= tmo_cnt_n;
      err_count    <= err_count_n;
    end
  end

endmodule

// File: tb/tb_wb_counter_bridge.sv
// Self-checking bench for wb_counter_bridge. Each bus transaction is planned
// as a timeline (when valid is high, when ack pulses, what data and flag
// values hold from which cycle on); a per-cycle compare process checks the
// DUT against that timeline, and directed steps pin key values literally.
module tb_wb_counter_bridge;

  localparam int          BITS    = 30;
  localparam int          TIMEOUT = 16;
  localparam int          MAXC    = 4096;
  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [31:0] STAT    = 32'h3000_0004;
  localparam logic [31:0] ERRV    = 32'hDEAD_BEEF;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_i = 1'b1;
  logic            wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]      wbs_sel_i = 4'h0;
  logic [31:0]     wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic            wbs_ack_o;
  logic [31:0]     wbs_dat_o;
  logic            valid;
  logic [3:0]      wstrb;
  logic [BITS-1:0] wdata;
  logic            ready = 1'b0;
  logic [BITS-1:0] rdata = '0;
  logic            timeout_flag;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_counter_bridge dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .valid(valid), .wstrb(wstrb), .wdata(wdata),
    .ready(ready), .rdata(rdata), .timeout_flag(timeout_flag)
  );

  int total = 0;
  int bad   = 0;
  int cycle;
  bit chk_en = 1'b0;

  // Expected timeline, indexed by the clock edge after which it must hold.
  bit          exp_valid [MAXC];
  bit          exp_ack   [MAXC];
  bit          exp_flag  [MAXC];
  logic [31:0] exp_dat   [MAXC];
  logic [3:0]  exp_wstrb [MAXC];
  logic [29:0] exp_wdata [MAXC];

  // Abstract model state.
  bit         m_flag = 1'b0;
  logic [7:0] m_err  = 8'd0;

  // Observed activity counters.
  int          valid_cnt = 0, ack_cnt = 0, hs_cnt = 0;
  logic [3:0]  last_wstrb = 4'h0;
  logic [29:0] last_wdata = 30'h0;

  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) cycle <= 0;
    else          cycle <= cycle + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  function automatic void fill_dat(input int from, input logic [31:0] v);
    for (int c = from; c < MAXC; c++) exp_dat[c] = v;
  endfunction

  function automatic void fill_flag(input int from, input bit v);
    for (int c = from; c < MAXC; c++) exp_flag[c] = v;
  endfunction

  // Per-cycle compare against the planned timeline.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (valid) begin
        valid_cnt++;
        last_wstrb = wstrb;
        last_wdata = wdata;
      end
      if (wbs_ack_o) ack_cnt++;
      if (valid && ready) hs_cnt++;
    end
    if (chk_en && !wb_rst_i && cycle < MAXC) begin
      check("valid", {31'b0, valid}, {31'b0, exp_valid[cycle]});
      check("ack", {31'b0, wbs_ack_o}, {31'b0, exp_ack[cycle]});
      check("dat_o", wbs_dat_o, exp_dat[cycle]);
      check("flag", {31'b0, timeout_flag}, {31'b0, exp_flag[cycle]});
      if (exp_valid[cycle]) begin
        check("wstrb", {28'b0, wstrb}, {28'b0, exp_wstrb[cycle]});
        check("wdata", {2'b0, wdata}, {2'b0, exp_wdata[cycle]});
      end
    end
  end

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic drop_bus();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
  endtask

  // Data-word access; the counter answers with a ready pulse r cycles after
  // stb is sampled (r > TIMEOUT-1 means the bridge times out first).
  task automatic data_access(input bit we, input logic [3:0] sel, input logic [31:0] dat,
                             input int r, input logic [29:0] rd);
    int e0, rsp;
    bit tmo;
    logic [31:0] v;
    e0 = cycle + 1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel; wbs_adr_i = BASE; wbs_dat_i = dat;
    if (r + 1 <= TIMEOUT) begin
      rsp = e0 + r + 1; tmo = 1'b0; v = {2'b00, rd};
    end else begin
      rsp = e0 + TIMEOUT; tmo = 1'b1; v = ERRV;
    end
    for (int c = e0; c < rsp; c++) begin
      exp_valid[c] = 1'b1;
      exp_wstrb[c] = we ? sel : 4'b0000;
      exp_wdata[c] = dat[29:0];
    end
    exp_ack[rsp] = 1'b1;
    fill_dat(rsp, v);
    if (tmo) begin
      m_flag = 1'b1;
      fill_flag(rsp, 1'b1);
      m_err = (m_err == 8'hFF) ? m_err : m_err + 8'd1;
    end
    repeat (80) begin
      step();
      ready = (cycle == e0 + r);
      rdata = ready ? rd : 30'($urandom);
      if (cycle == rsp) drop_bus();
      if (cycle >= rsp && (r >= 64 || cycle > e0 + r)) break;
    end
    ready = 1'b0;
    drop_bus();
    step();
  endtask

  task automatic status_access(input bit we, input logic [3:0] sel, input logic [31:0] dat,
                               output logic [31:0] v);
    int e0;
    e0 = cycle + 1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel; wbs_adr_i = STAT; wbs_dat_i = dat;
    v = {16'h0000, m_err, 7'h00, m_flag};
    exp_ack[e0] = 1'b1;
    fill_dat(e0, v);
    if (we && sel[0] && dat[0]) begin
      m_flag = 1'b0;
      fill_flag(e0, 1'b0);
    end
    step();
    drop_bus();
    step();
  endtask

  task automatic miss_access(input int n, input logic [31:0] adr, input bit stb);
    wbs_cyc_i = 1'b1; wbs_stb_i = stb; wbs_we_i = 1'($urandom);
    wbs_sel_i = 4'($urandom); wbs_adr_i = adr; wbs_dat_i = $urandom;
    repeat (n) step();
    drop_bus();
    step();
  endtask

  // Master drops cyc a cycles into REQ, then the counter answers late.
  task automatic abort_access(input int a, input logic [29:0] rd);
    int e0;
    logic [31:0] dat;
    e0 = cycle + 1;
    dat = $urandom;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = BASE; wbs_dat_i = dat;
    for (int c = e0; c <= e0 + a; c++) begin
      exp_valid[c] = 1'b1;
      exp_wstrb[c] = 4'b0000;
      exp_wdata[c] = dat[29:0];
    end
    repeat (40) begin
      step();
      if (cycle == e0 + a) drop_bus();
      ready = (cycle == e0 + a + 2);
      rdata = rd;
      if (cycle >= e0 + a + 3) break;
    end
    ready = 1'b0;
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int vc0, ac0, hs0;
    int rtab[10] = '{1, 2, 3, 5, 8, 14, 15, 16, 17, 1000};

    for (int c = 0; c < MAXC; c++) begin
      exp_dat[c]   = 32'h0;
      exp_wstrb[c] = 4'h0;
      exp_wdata[c] = 30'h0;
    end

    repeat (3) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_ack", {31'b0, wbs_ack_o}, 32'h0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_flag", {31'b0, timeout_flag}, 32'h0);
    check("rst_wstrb", {28'b0, wstrb}, 32'h0);
    check("rst_wdata", {2'b0, wdata}, 32'h0);
    chk_en = 1'b1;
    step();

    // Read with a one-cycle counter response.
    hs0 = hs_cnt; ac0 = ack_cnt;
    data_access(1'b0, 4'hF, 32'h1234_5678, 1, 30'h0000_1234);
    check("read_dat", wbs_dat_o, 32'h0000_1234);
    check("read_handshakes", hs_cnt - hs0, 32'd1);
    check("read_acks", ack_cnt - ac0, 32'd1);

    // Partial write.
    data_access(1'b1, 4'b0011, 32'hAABB_CCDD, 1, 30'h0);
    check("write_wstrb", {28'b0, last_wstrb}, 32'h3);
    check("write_wdata", {2'b0, last_wdata}, 32'h2ABB_CCDD);

    // Counter never answers.
    vc0 = valid_cnt;
    data_access(1'b0, 4'hF, 32'h0, 1000, 30'h0);
    check("tmo_valid_cycles", vc0 == valid_cnt ? 32'd0 : 32'(valid_cnt - vc0), 32'd16);
    check("tmo_dat", wbs_dat_o, 32'hDEAD_BEEF);
    check("tmo_flag", {31'b0, timeout_flag}, 32'h1);
    status_access(1'b0, 4'hF, 32'h0, v);
    check("stat_model_after_tmo", v, 32'h0000_0101);
    check("stat_read_after_tmo", wbs_dat_o, 32'h0000_0101);

    // W1C clear of the flag.
    status_access(1'b1, 4'b0001, 32'h0000_0001, v);
    check("stat_w1c_read", wbs_dat_o, 32'h0000_0101);
    check("stat_w1c_flag", {31'b0, timeout_flag}, 32'h0);
    status_access(1'b0, 4'hF, 32'h0, v);
    check("stat_after_clear", wbs_dat_o, 32'h0000_0100);

    // Miss address: nothing happens.
    vc0 = valid_cnt; ac0 = ack_cnt;
    miss_access(20, 32'h3000_0008, 1'b1);
    check("miss_valid", 32'(valid_cnt - vc0), 32'd0);
    check("miss_ack", 32'(ack_cnt - ac0), 32'd0);

    // Master abort then a late ready.
    vc0 = valid_cnt; ac0 = ack_cnt;
    abort_access(2, 30'h0000_0BAD);
    check("abort_valid_cycles", 32'(valid_cnt - vc0), 32'd3);
    check("abort_ack", 32'(ack_cnt - ac0), 32'd0);
    data_access(1'b0, 4'hF, 32'h0, 2, 30'h000A_BCDE);
    check("after_abort_read", wbs_dat_o, 32'h000A_BCDE);

    // Randomized traffic.
    for (int i = 0; i < 60 && cycle < MAXC - 200; i++) begin
      int k;
      logic [31:0] adr;
      k = $urandom_range(0, 9);
      if (k <= 4) begin
        data_access(1'($urandom), 4'($urandom), $urandom,
                    rtab[$urandom_range(0, 9)], 30'($urandom));
      end else if (k <= 6) begin
        status_access(1'($urandom), 4'($urandom), $urandom, v);
      end else if (k == 7) begin
        adr = ($urandom_range(0, 1) == 0) ? BASE + 32'h1 : $urandom;
        if (adr == BASE || adr == STAT) adr = BASE + 32'h8;
        miss_access($urandom_range(1, 6), adr, 1'b1);
      end else if (k == 8) begin
        abort_access($urandom_range(1, 10), 30'($urandom));
      end else begin
        miss_access($urandom_range(1, 4), BASE, 1'b0);
      end
      repeat ($urandom_range(0, 2)) step();
    end

    // Asynchronous reset in the middle of a request.
    chk_en = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'hF; wbs_adr_i = BASE; wbs_dat_i = 32'h1555_5555;
    repeat (3) step();
    check("pre_rst_valid", {31'b0, valid}, 32'h1);
    #3;
    wb_rst_i = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, valid}, 32'h0);
    check("async_rst_ack", {31'b0, wbs_ack_o}, 32'h0);
    check("async_rst_dat", wbs_dat_o, 32'h0);
    check("async_rst_flag", {31'b0, timeout_flag}, 32'h0);
    check("async_rst_wstrb", {28'b0, wstrb}, 32'h0);
    check("async_rst_wdata", {2'b0, wdata}, 32'h0);
    drop_bus();
    step();
    wb_rst_i = 1'b0;
    step();
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = STAT;
    step();
    check("post_rst_stat_ack", {31'b0, wbs_ack_o}, 32'h1);
    check("post_rst_stat_dat", wbs_dat_o, 32'h0);
    drop_bus();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
